// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the loader FSM state type, default framing constants and the address width.
package loader_pkg;

    localparam int PM_AW = 8;

    localparam logic [7:0]       DEF_SYNC_BYTE  = 8'hA5;
    localparam logic [PM_AW-1:0] DEF_START_ADDR = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        RESP
    } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit additive checksum accumulator with clear and add-enable.
// Ports: clk, sync_reset, clear, add_en, din[7:0] in; sum[7:0] out (mod-256 running sum).
module loader_checksum (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sum <= 8'h00;
        end else if (clear) begin
            sum <= 8'h00;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader: writes payload into program memory,
// verifies an additive checksum and holds the CPU in reset until an image passes.
// Ports: clk, sync_reset; host in_data/in_valid/in_ready; pm_wr_addr/pm_wr_data/pm_wren
// write port; cpu_hold, load_done (pulse), load_error (sticky), byte_count status.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [PM_AW-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [7:0]       SYNC_BYTE  = DEF_SYNC_BYTE
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PM_AW-1:0] pm_wr_addr,
    output logic [7:0]       pm_wr_data,
    output logic             pm_wren,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_error,
    output logic [7:0]       byte_count
);

    loader_state_t state_q;
    loader_state_t state_d;

    logic [7:0] len_q;
    logic [7:0] sum;
    logic       accept;
    logic       is_sync;
    logic       last_byte;
    logic       chk_clear;
    logic       chk_add;

    assign in_ready = (state_q != RESP);
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);

    // LEN = 0 means 256 bytes: the count wraps to 0 on the 256th byte.
    assign last_byte = ((byte_count + 8'd1) == len_q);

    assign chk_clear = accept && (state_q == LEN);
    assign chk_add   = accept && (state_q == DATA);

    loader_checksum u_checksum (
        .clk        (clk),
        .sync_reset (sync_reset),
        .clear      (chk_clear),
        .add_en     (chk_add),
        .din        (in_data),
        .sum        (sum)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && is_sync) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) begin
                    state_d = CHK;
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            len_q      <= 8'h00;
            pm_wr_addr <= '0;
            pm_wr_data <= 8'h00;
            pm_wren    <= 1'b0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            byte_count <= 8'h00;
        end else begin
            pm_wren   <= 1'b0;
            load_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A reload halts a running program before any write lands.
                    if (accept && is_sync) begin
                        cpu_hold <= 1'b1;
                    end
                end
                LEN: begin
                    if (accept) begin
                        len_q      <= in_data;
                        byte_count <= 8'h00;
                        load_error <= 1'b0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        pm_wren    <= 1'b1;
                        pm_wr_addr <= START_ADDR + byte_count;
                        pm_wr_data <= in_data;
                        byte_count <= byte_count + 8'd1;
                    end
                end
                CHK: begin
                    // Registered here so done/hold/error appear in the RESP cycle.
                    if (accept) begin
                        if (in_data == sum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
